// File: rtl/sram_confreg_resp.sv
// ============================================================================
// Module:   sram_confreg_resp
// Purpose:  Data RAM plus LED/SWITCH/NUM/TIMER config registers behind one SRAM port.
//           Optional TIMER register is built only when CONFREG_TIMER_EN is defined.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sram_confreg_resp #(
    parameter int          RAM_AW    = 10,
    parameter logic [15:0] CONF_BASE = 16'hbfaf
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data
);

    localparam logic [15:0] OFF_LED    = 16'hf000;
    localparam logic [15:0] OFF_SWITCH = 16'hf004;
    localparam logic [15:0] OFF_NUM    = 16'hf008;
    localparam logic [15:0] OFF_TIMER  = 16'he000;

    logic              conf_sel;
    logic [15:0]       offset;
    logic [RAM_AW-1:0] word_idx;
    logic              wr;
    logic [31:0]       wmask;
    logic [31:0]       conf_rd;
    logic [31:0]       timer;
    logic [31:0]       ram_q;
    logic [31:0]       conf_q;
    logic              ram_sel_q;
    logic [15:0]       led_r;
    logic [31:0]       num_r;

    logic [31:0] mem [2**RAM_AW];

    assign conf_sel = (data_sram_addr[31:16] == CONF_BASE);
    assign offset   = data_sram_addr[15:0];
    assign word_idx = data_sram_addr[RAM_AW+1:2];
    assign wr       = data_sram_en && (data_sram_wen != 4'b0000);
    assign wmask    = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                       {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    // RAM is not reset; the read register captures the old word on a write (read-before-write)
    always_ff @(posedge clk) begin
        if (data_sram_en && !conf_sel) begin
            ram_q <= mem[word_idx];
            if (data_sram_wen != 4'b0000) begin
                mem[word_idx] <= merge(mem[word_idx], data_sram_wdata, wmask);
            end
        end
    end

`ifdef CONFREG_TIMER_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= 32'd0;
        end else if (wr && conf_sel && (offset == OFF_TIMER)) begin
            timer <= merge(timer, data_sram_wdata, wmask);
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    assign timer = 32'd0;
`endif

    always_comb begin
        conf_rd = 32'd0;
        case (offset)
            OFF_LED:    conf_rd = {16'd0, led_r};
            OFF_SWITCH: conf_rd = {24'd0, switch};
            OFF_NUM:    conf_rd = num_r;
            OFF_TIMER:  conf_rd = timer;
            default:    conf_rd = 32'd0;
        endcase
    end

    // Cleared select routes rdata to the zeroed conf_q, so reset forces rdata to 0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_r     <= 16'h0000;
            num_r     <= 32'd0;
            conf_q    <= 32'd0;
            ram_sel_q <= 1'b0;
        end else begin
            if (data_sram_en) begin
                ram_sel_q <= !conf_sel;
                if (conf_sel) begin
                    conf_q <= conf_rd;
                end
            end
            if (wr && conf_sel && (offset == OFF_LED)) begin
                led_r <= (led_r & ~wmask[15:0]) | (data_sram_wdata[15:0] & wmask[15:0]);
            end
            if (wr && conf_sel && (offset == OFF_NUM)) begin
                num_r <= merge(num_r, data_sram_wdata, wmask);
            end
        end
    end

    assign data_sram_rdata = ram_sel_q ? ram_q : conf_q;
    assign led             = led_r;
    assign num_data        = num_r;

endmodule

`default_nettype wire

// File: tb/tb_sram_confreg_resp.sv
// ============================================================================
// Module:   tb_sram_confreg_resp
// Purpose:  Table-driven scoreboard bench for sram_confreg_resp.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sram_confreg_resp;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic [7:0]  sw = 8'h00;
    logic [15:0] led;
    logic [31:0] num;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  sw;
        logic        chk;
        logic [31:0] rd;
        logic [15:0] led;
        logic [31:0] num;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [31:0] rd;
        logic [15:0] led;
        logic [31:0] num;
        string       name;
    } exp_t;

    exp_t  sb[$];
    vec_t  tbl[19];

    sram_confreg_resp #(.RAM_AW(10), .CONF_BASE(16'hbfaf)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .switch          (sw),
        .led             (led),
        .num_data        (num)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_t e;
        en = v.en; wen = v.wen; addr = v.addr; wdata = v.wdata; sw = v.sw;
        sb.push_back('{v.chk, v.rd, v.led, v.num, name});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk) check({e.name, " rdata"}, rdata, e.rd);
        check({e.name, " led"}, {16'd0, led}, {16'd0, e.led});
        check({e.name, " num"}, num, e.num);
    endtask

    localparam logic [31:0] A_LED = 32'hbfaff000;
    localparam logic [31:0] A_SW  = 32'hbfaff004;
    localparam logic [31:0] A_NUM = 32'hbfaff008;
    localparam logic [31:0] A_UNK = 32'hbfaff00c;
    localparam logic [31:0] A_TMR = 32'hbfafe000;

    initial begin
        vec_t v;
        // {en, wen, addr, wdata, switch, chk, rdata, led, num}
        tbl[0]  = '{1'b1, 4'hf, 32'h10,   32'h12345678, 8'h00, 1'b0, 32'h0,        16'h0000, 32'h0};
        tbl[1]  = '{1'b1, 4'h0, 32'h10,   32'h0,        8'h00, 1'b1, 32'h12345678, 16'h0000, 32'h0};
        tbl[2]  = '{1'b1, 4'h2, 32'h10,   32'hAABBCCDD, 8'h00, 1'b1, 32'h12345678, 16'h0000, 32'h0};
        tbl[3]  = '{1'b1, 4'h0, 32'h10,   32'h0,        8'h00, 1'b1, 32'h1234CC78, 16'h0000, 32'h0};
        tbl[4]  = '{1'b0, 4'hf, 32'h10,   32'h0,        8'h00, 1'b1, 32'h1234CC78, 16'h0000, 32'h0};
        tbl[5]  = '{1'b0, 4'hf, A_LED,    32'hFFFFFFFF, 8'h00, 1'b1, 32'h1234CC78, 16'h0000, 32'h0};
        tbl[6]  = '{1'b0, 4'h0, A_SW,     32'h0,        8'h33, 1'b1, 32'h1234CC78, 16'h0000, 32'h0};
        tbl[7]  = '{1'b1, 4'h0, 32'h10,   32'h0,        8'h00, 1'b1, 32'h1234CC78, 16'h0000, 32'h0};
        tbl[8]  = '{1'b1, 4'h0, A_SW,     32'h0,        8'h5A, 1'b1, 32'h0000005A, 16'h0000, 32'h0};
        tbl[9]  = '{1'b1, 4'hf, A_LED,    32'hFFFF0F0F, 8'h00, 1'b1, 32'h0,        16'h0F0F, 32'h0};
        tbl[10] = '{1'b1, 4'h0, A_LED,    32'h0,        8'h00, 1'b1, 32'h00000F0F, 16'h0F0F, 32'h0};
        tbl[11] = '{1'b1, 4'h5, A_NUM,    32'h11223344, 8'h00, 1'b1, 32'h0,        16'h0F0F, 32'h00220044};
        tbl[12] = '{1'b1, 4'h0, A_NUM,    32'h0,        8'h00, 1'b1, 32'h00220044, 16'h0F0F, 32'h00220044};
        tbl[13] = '{1'b1, 4'hf, A_UNK,    32'hDEADBEEF, 8'h00, 1'b1, 32'h0,        16'h0F0F, 32'h00220044};
        tbl[14] = '{1'b1, 4'h0, A_UNK,    32'h0,        8'h00, 1'b1, 32'h0,        16'h0F0F, 32'h00220044};
        // 0x1010 aliases word 4 (0x10) with a 10-bit word address
        tbl[15] = '{1'b1, 4'hf, 32'h1010, 32'hCAFEF00D, 8'h00, 1'b1, 32'h1234CC78, 16'h0F0F, 32'h00220044};
        tbl[16] = '{1'b1, 4'h0, 32'h10,   32'h0,        8'h00, 1'b1, 32'hCAFEF00D, 16'h0F0F, 32'h00220044};
        tbl[17] = '{1'b1, 4'h1, A_LED,    32'h000000AB, 8'h00, 1'b1, 32'h00000F0F, 16'h0FAB, 32'h00220044};
        tbl[18] = '{1'b1, 4'h0, A_SW,     32'h0,        8'hA5, 1'b1, 32'h000000A5, 16'h0FAB, 32'h00220044};

        #1 resetn = 1'b0;
        #1;
        check("reset rdata", rdata, 32'h0);
        check("reset led", {16'd0, led}, 32'h0);
        check("reset num", num, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;

        for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Timer: load FFFFFFFE, idle two cycles, then two reads
        v = '{1'b1, 4'hf, A_TMR, 32'hFFFFFFFE, 8'h00, 1'b0, 32'h0, 16'h0FAB, 32'h00220044};
        apply(v, "tmr_wr");
        v.en = 1'b0; v.wen = 4'h0;
        apply(v, "tmr_idle0");
        apply(v, "tmr_idle1");
        v.en = 1'b1; v.chk = 1'b1; v.rd = 32'h0;
        apply(v, "tmr_wrap");
`ifdef CONFREG_TIMER_EN
        v.rd = 32'h1;
`endif
        apply(v, "tmr_next");

        // Hold across idle cycles, then asynchronous reset with a read in flight
        v = '{1'b1, 4'h0, 32'h10, 32'h0, 8'h00, 1'b1, 32'hCAFEF00D, 16'h0FAB, 32'h00220044};
        apply(v, "pre_rst_rd");
        v.en = 1'b0;
        apply(v, "pre_rst_hold");
        en = 1'b1; wen = 4'h0; addr = 32'h10;
        #3 resetn = 1'b0;
        #1;
        check("async rst rdata", rdata, 32'h0);
        check("async rst led", {16'd0, led}, 32'h0);
        check("async rst num", num, 32'h0);
        @(posedge clk);
        #1;
        check("rst inflight rdata", rdata, 32'h0);
        resetn = 1'b1;
        v = '{1'b1, 4'h0, A_TMR, 32'h0, 8'h00, 1'b1, 32'h0, 16'h0000, 32'h0};
        apply(v, "post_rst_tmr");
        v = '{1'b1, 4'h0, 32'h10, 32'h0, 8'h00, 1'b1, 32'hCAFEF00D, 16'h0000, 32'h0};
        apply(v, "post_rst_ram");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sram_confreg_resp.md
SRAM_CONFREG_RESP -- requirements
Module: sram_confreg_resp

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning word-address width of the internal data RAM (2^RAM_AW 32-bit words).
REQ-002 SHALL have parameter CONF_BASE, default 16'hbfaf, meaning the value of addr[31:16] that selects the config-register space.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port data_sram_en, input, 1, request strobe from the CPU MEM stage.
REQ-006 SHALL have port data_sram_wen, input, 4, byte write enables; wen[i] writes byte lane i (bits 8i+7:8i).
REQ-007 SHALL have port data_sram_addr, input, 32, byte address; bits 1:0 ignored.
REQ-008 SHALL have port data_sram_wdata, input, 32, write data.
REQ-009 SHALL have port data_sram_rdata, output, 32, read data.
REQ-010 SHALL have port switch, input, 8, board switch levels.
REQ-011 SHALL have port led, output, 16, LED register value.
REQ-012 SHALL have port num_data, output, 32, seven-segment number register value.

Function
REQ-013 SHALL decode conf_sel = (addr[31:16] == CONF_BASE); otherwise the access targets RAM word addr[RAM_AW+1:2], upper address bits ignored (aliasing).
REQ-014 SHALL map config offsets addr[15:0]: 16'hf000 LED (R/W, low 16 bits), 16'hf004 SWITCH (RO, zero-extended), 16'hf008 NUM (R/W), 16'he000 TIMER (R/W); other config offsets read 0, writes ignored.
REQ-015 SHALL perform writes when en=1 and wen!=0, committing only enabled byte lanes at the rising edge of that cycle.
REQ-016 SHALL return read data with exactly one cycle latency: for a request at cycle N, rdata is valid in cycle N+1.
REQ-017 SHALL hold data_sram_rdata unchanged in every cycle following a cycle with en=0 (rdata register loads only when en=1).
REQ-018 SHALL, for en=1 with wen!=0, load rdata with the pre-write (old) contents of the addressed word (read-before-write).
REQ-019 SHALL register the conf_sel/offset of the request so the cycle-N+1 mux selects the correct source; TIMER and SWITCH are sampled in cycle N.
REQ-020 SHALL increment TIMER by 1 every cycle, wrapping 32'hffffffff -> 0.
REQ-021 SHALL, on a TIMER write, load the byte-merged write value in that edge instead of the increment (write wins), incrementing from the next cycle.
REQ-022 SHALL treat en=0 as no access regardless of wen/addr/wdata.
REQ-023 SHALL drive led and num_data directly from their registers (no extra latency).

Reset
REQ-024 SHALL, while resetn=0, force immediately (asynchronously): data_sram_rdata=0, led=16'h0000, num_data=0, TIMER=0, registered select state cleared.
REQ-025 SHALL NOT reset RAM contents; RAM content after reset is undefined until written.
REQ-026 SHALL discard a read in flight when reset asserts; the first rdata after reset release comes from the first request after release.

Configuration
REQ-027 SHALL implement macro CONFREG_TIMER_EN: defined -> TIMER register per REQ-014/020/021; undefined -> no timer flops, offset 16'he000 reads 0, writes ignored.

Verification
REQ-028 SHALL cover: write RAM addr 0x00000010 wen=4'hf wdata=0x12345678, then read same -> rdata=0x12345678 the cycle after the read request.
REQ-029 SHALL cover: write 0x00000010 wen=4'b0010 wdata=0xAABBCCDD over 0x12345678 -> subsequent read returns 0x1234CC78; same-cycle returned rdata was old 0x12345678.
REQ-030 SHALL cover: switch=8'h5A, read 0xbfaff004 -> rdata=0x0000005A; write 0xbfaff000 wdata=0xFFFF0F0F -> led=16'h0F0F next cycle.
REQ-031 SHALL cover (CONFREG_TIMER_EN): write 0xbfafe000 wdata=0xFFFFFFFE, read it 2 cycles later -> sample 0 (wrap), next-cycle sample 1; without macro the read returns 0.
REQ-032 SHALL cover: read 0x00000010 then en=0 for 3 cycles -> rdata stays 0x1234CC78; assert resetn=0 mid-sequence -> rdata, led, num_data, TIMER = 0 immediately without a clock edge.
